// File: rtl/iram_arbiter_if.sv
// iram_arbiter_if: bundles the fetch, loader and IRAM-side signals of the
// instruction RAM arbiter. The arbiter uses the slave modport; the
// surrounding logic (fetch stage, loader, iram) uses the master modport.
interface iram_arbiter_if #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned INSTR_W = 33
);
  // fetch unit (read requester)
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_ready;
  logic               fetch_rvalid;
  logic [INSTR_W-1:0] fetch_rdata;

  // program loader (write requester)
  logic               load_req;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               load_ready;

  // IRAM side
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rnw;
  logic [INSTR_W-1:0] mem_wdata;
  logic               mem_wdata_oe;
  logic [INSTR_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_ready, fetch_rvalid, fetch_rdata,
    input  load_req, load_addr, load_data,
    output load_ready,
    output mem_addr, mem_rnw, mem_wdata, mem_wdata_oe,
    input  mem_rdata
  );

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_ready, fetch_rvalid, fetch_rdata,
    output load_req, load_addr, load_data,
    input  load_ready,
    input  mem_addr, mem_rnw, mem_wdata, mem_wdata_oe,
    output mem_rdata
  );
endinterface

// File: rtl/iram_arbiter.sv
// iram_arbiter: shares the single IRAM port between fetch reads and loader
// writes. Writes take one cycle in WR; reads take RD (IRAM samples address)
// then RD_CAP (data captured), so one read is outstanding at a time.
// Optional feature macro: IRAM_ARB_FAIRNESS_EN -- bounds how many loader
// grants may be issued while a fetch is waiting (STARVE_LIMIT). Without it
// the loader has strict priority.
module iram_arbiter #(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned INSTR_W      = 33,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  iram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WR     = 2'd1,
    S_RD     = 2'd2,
    S_RD_CAP = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   grant_load;
  logic   grant_fetch;

`ifdef IRAM_ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q;
  logic             fetch_starved;

  assign fetch_starved = (32'(starve_q) >= STARVE_LIMIT);

  // Count loader grants that bypass a waiting fetch; once starved the fetch
  // wins, so the counter never needs to exceed STARVE_LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (grant_fetch || !bus.fetch_req) begin
        starve_q <= '0;
      end else if (grant_load) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end
`endif

  // Arbitration between the two requesters (only meaningful in IDLE).
  always_comb begin
`ifdef IRAM_ARB_FAIRNESS_EN
    grant_load = bus.load_req && !(bus.fetch_req && fetch_starved);
`else
    grant_load = bus.load_req;
`endif
    grant_fetch = bus.fetch_req && !grant_load;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and ready decode; readies are only offered in IDLE.
  always_comb begin
    state_d        = state_q;
    bus.load_ready  = 1'b0;
    bus.fetch_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.load_ready  = grant_load;
        bus.fetch_ready = grant_fetch;
        if (grant_load) begin
          state_d = S_WR;
        end else if (grant_fetch) begin
          state_d = S_RD;
        end
      end
      S_WR:     state_d = S_IDLE;
      S_RD:     state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered IRAM cycle outputs and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_addr     <= '0;
      bus.mem_rnw      <= 1'b1;
      bus.mem_wdata    <= '0;
      bus.mem_wdata_oe <= 1'b0;
      bus.fetch_rdata  <= '0;
      bus.fetch_rvalid <= 1'b0;
    end else begin
      bus.fetch_rvalid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_load) begin
            bus.mem_addr     <= bus.load_addr;
            bus.mem_rnw      <= 1'b0;
            bus.mem_wdata    <= bus.load_data;
            bus.mem_wdata_oe <= 1'b1;
          end else if (grant_fetch) begin
            bus.mem_addr <= bus.fetch_addr;
            bus.mem_rnw  <= 1'b1;
          end
        end
        S_WR: begin
          bus.mem_rnw      <= 1'b1;
          bus.mem_wdata_oe <= 1'b0;
        end
        S_RD_CAP: begin
          bus.fetch_rdata  <= bus.mem_rdata;
          bus.fetch_rvalid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iram_arbiter.sv
// tb_iram_arbiter: directed bench for iram_arbiter with a behavioural
// synchronous IRAM (address sampled on the rising edge, write when rnw=0).
module tb_iram_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 33;

  logic clk;
  logic rst_n;

  int n_cmp = 0;
  int n_mis = 0;

  iram_arbiter_if #(.ADDR_W(AW), .INSTR_W(DW)) bus ();

  iram_arbiter #(
    .ADDR_W      (AW),
    .INSTR_W     (DW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // IRAM model
  logic [DW-1:0] ram [64];
  logic [DW-1:0] rdq;
  always @(posedge clk) begin
    if (!bus.mem_rnw && bus.mem_wdata_oe) ram[bus.mem_addr] <= bus.mem_wdata;
    rdq <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = rdq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want summary before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit chk);
    int k;
    @(negedge clk);
    bus.load_req = 1'b1; bus.load_addr = a; bus.load_data = d;
    for (k = 0; k < 20; k++) begin
      #1;
      if (bus.load_ready) break;
      @(negedge clk);
    end
    check_eq("load_acc", 64'(bus.load_ready), 64'd1);
    if (!bus.load_ready) begin bus.load_req = 1'b0; return; end
    @(posedge clk); #1;
    bus.load_req = 1'b0;
    if (chk) begin
      check_eq("wr_rnw",   64'(bus.mem_rnw), 64'd0);
      check_eq("wr_oe",    64'(bus.mem_wdata_oe), 64'd1);
      check_eq("wr_addr",  64'(bus.mem_addr), 64'(a));
      check_eq("wr_wdata", 64'(bus.mem_wdata), 64'(d));
    end
    @(posedge clk); #1;
    if (chk) begin
      check_eq("wrx_rnw", 64'(bus.mem_rnw), 64'd1);
      check_eq("wrx_oe",  64'(bus.mem_wdata_oe), 64'd0);
      check_eq("ram_hold", 64'(ram[a]), 64'(d));
    end
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    int k;
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = a;
    for (k = 0; k < 20; k++) begin
      #1;
      if (bus.fetch_ready) break;
      @(negedge clk);
    end
    check_eq({tag, "_acc"}, 64'(bus.fetch_ready), 64'd1);
    if (!bus.fetch_ready) begin bus.fetch_req = 1'b0; return; end
    @(posedge clk); #1;                 // accept edge N
    bus.fetch_req = 1'b0;
    check_eq({tag, "_rv_n"}, 64'(bus.fetch_rvalid), 64'd0);
    @(posedge clk); #1;                 // N+1
    check_eq({tag, "_rv_n1"}, 64'(bus.fetch_rvalid), 64'd0);
    @(posedge clk); #1;                 // N+2
    check_eq({tag, "_rv_n2"}, 64'(bus.fetch_rvalid), 64'd1);
    check_eq({tag, "_data"}, 64'(bus.fetch_rdata), 64'(exp));
    @(posedge clk); #1;                 // N+3
    check_eq({tag, "_rv_n3"}, 64'(bus.fetch_rvalid), 64'd0);
    check_eq({tag, "_hold"}, 64'(bus.fetch_rdata), 64'(exp));
  endtask

  logic [DW-1:0] pre [4] = '{33'h1_5555_0000, 33'h0_AAAA_0001, 33'h1_FFFF_FFFF, 33'h0_0000_0003};

  initial begin
    int acc [4];
    int idx;
    bit acc_now, lacc, facc;
    logic [DW-1:0] got [$];
    int nload, fetch_at, exp_loads;

    rst_n = 1'b0;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.load_req = 1'b0;  bus.load_addr = '0; bus.load_data = '0;

    // reset state
    @(negedge clk); @(negedge clk);
    check_eq("rst_addr",   64'(bus.mem_addr), 64'd0);
    check_eq("rst_rnw",    64'(bus.mem_rnw), 64'd1);
    check_eq("rst_wdata",  64'(bus.mem_wdata), 64'd0);
    check_eq("rst_oe",     64'(bus.mem_wdata_oe), 64'd0);
    check_eq("rst_rdata",  64'(bus.fetch_rdata), 64'd0);
    check_eq("rst_rvalid", 64'(bus.fetch_rvalid), 64'd0);
    check_eq("rst_lrdy",   64'(bus.load_ready), 64'd0);
    check_eq("rst_frdy",   64'(bus.fetch_ready), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_eq("idle_rvalid", 64'(bus.fetch_rvalid), 64'd0);
      check_eq("idle_oe",     64'(bus.mem_wdata_oe), 64'd0);
    end

    // readies follow requests in IDLE, loader wins; dropped before the edge
    bus.fetch_req = 1'b1; #1;
    check_eq("idle_frdy", 64'(bus.fetch_ready), 64'd1);
    check_eq("idle_lrdy0", 64'(bus.load_ready), 64'd0);
    bus.load_req = 1'b1; #1;
    check_eq("prio_lrdy", 64'(bus.load_ready), 64'd1);
    check_eq("prio_frdy", 64'(bus.fetch_ready), 64'd0);
    bus.load_req = 1'b0; bus.fetch_req = 1'b0;
    @(posedge clk); #1;
    check_eq("drop_rnw",  64'(bus.mem_rnw), 64'd1);
    check_eq("drop_addr", 64'(bus.mem_addr), 64'd0);

    // write then read back
    do_load(6'h05, 33'h0_1200_0020, 1'b1);
    do_fetch(6'h05, 33'h0_1200_0020, "rd05");

    // preload and back-to-back fetches
    for (int i = 0; i < 4; i++) do_load(6'(i), pre[i], 1'b0);
    idx = 0;
    for (int i = 0; i < 4; i++) acc[i] = 0;
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 6'd0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus.fetch_rvalid) got.push_back(bus.fetch_rdata);
      acc_now = bus.fetch_req && bus.fetch_ready;
      if (acc_now) begin acc[idx] = c; idx++; end
      @(posedge clk); #1;
      if (acc_now) begin
        if (idx < 4) bus.fetch_addr = 6'(idx);
        else bus.fetch_req = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("b2b_count", 64'(idx), 64'd4);
    check_eq("b2b_first", 64'(acc[0]), 64'd0);
    for (int i = 1; i < 4; i++)
      check_eq("b2b_gap", 64'(acc[i] - acc[i-1]), 64'd3);
    check_eq("b2b_nrv", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      check_eq("b2b_data", 64'(got[i]), 64'(pre[i]));

    // simultaneous requests: loads hold, fetch waits
`ifdef IRAM_ARB_FAIRNESS_EN
    exp_loads = 4;
`else
    exp_loads = 6;
`endif
    nload = 0; fetch_at = -1;
    @(negedge clk);
    bus.load_req = 1'b1; bus.load_addr = 6'd8; bus.load_data = 33'h0_0000_0100;
    bus.fetch_req = 1'b1; bus.fetch_addr = 6'd2;
    for (int c = 0; c < 40; c++) begin
      #1;
      check_eq("mutex", 64'(bus.load_ready && bus.fetch_ready), 64'd0);
      lacc = bus.load_req && bus.load_ready;
      facc = bus.fetch_req && bus.fetch_ready;
      @(posedge clk); #1;
      if (lacc) begin
        nload++;
        bus.load_addr = 6'(8 + nload);
        bus.load_data = 33'(256 + nload);
        if (nload == 6) bus.load_req = 1'b0;
      end
      if (facc) begin
        fetch_at = nload;
        bus.fetch_req = 1'b0; bus.load_req = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check_eq("sim_loads", 64'(fetch_at), 64'(exp_loads));
    for (int k = 0; k < 6; k++) begin
      if (bus.fetch_rvalid) break;
      @(posedge clk); #1;
    end
    check_eq("sim_rv",   64'(bus.fetch_rvalid), 64'd1);
    check_eq("sim_data", 64'(bus.fetch_rdata), 64'(pre[2]));
    check_eq("sim_ram8", 64'(ram[8]), 64'h100);

    // reset during WR: wdata_oe must drop without a clock edge
    @(negedge clk);
    bus.load_req = 1'b1; bus.load_addr = 6'd20; bus.load_data = 33'h1_2345_6789;
    #1; check_eq("rw_lrdy", 64'(bus.load_ready), 64'd1);
    @(posedge clk); #1;
    bus.load_req = 1'b0;
    check_eq("rw_oe_on", 64'(bus.mem_wdata_oe), 64'd1);
    #1; rst_n = 1'b0; #1;
    check_eq("rw_oe_off", 64'(bus.mem_wdata_oe), 64'd0);
    check_eq("rw_rnw",    64'(bus.mem_rnw), 64'd1);
    check_eq("rw_wdata",  64'(bus.mem_wdata), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // reset during RD_CAP: read discarded
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 6'h05;
    #1; check_eq("rr_frdy", 64'(bus.fetch_ready), 64'd1);
    @(posedge clk); #1;
    bus.fetch_req = 1'b0;
    check_eq("rr_addr_rd", 64'(bus.mem_addr), 64'h05);
    @(posedge clk);                     // now in RD_CAP
    @(negedge clk); rst_n = 1'b0; #1;
    check_eq("rr_rvalid", 64'(bus.fetch_rvalid), 64'd0);
    check_eq("rr_rdata",  64'(bus.fetch_rdata), 64'd0);
    check_eq("rr_addr",   64'(bus.mem_addr), 64'd0);
    check_eq("rr_rnw",    64'(bus.mem_rnw), 64'd1);
    check_eq("rr_oe",     64'(bus.mem_wdata_oe), 64'd0);
    @(posedge clk); #1;
    check_eq("rr_rvalid2", 64'(bus.fetch_rvalid), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rr_rvalid3", 64'(bus.fetch_rvalid), 64'd0);
    do_fetch(6'h05, 33'h0_1200_0020, "rd_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/iram_arbiter.md
# iram_arbiter

Single-port arbiter and sequencer for the instruction RAM. Shares its one address/data port between the CPU fetch unit (reads) and the program loader (writes). Issues correctly timed `read_not_write`/address/data cycles and returns read data with a valid strobe. Sits between the fetch stage, the loader and the `iram` instance in the CPU top level.

## Interface
- `ADDR_W`, default 6: IRAM word-address width (64 words).
- `INSTR_W`, default 33: instruction word width.
- `STARVE_LIMIT`, default 4: consecutive loader grants allowed while a fetch waits (used only with the fairness feature).

- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `fetch_req` input 1: fetch read request.
- `fetch_addr` input ADDR_W: fetch word address.
- `fetch_ready` output 1: fetch request accepted this cycle.
- `fetch_rvalid` output 1: one-cycle strobe; `fetch_rdata` is valid.
- `fetch_rdata` output INSTR_W: returned instruction word.
- `load_req` input 1: loader write request.
- `load_addr` input ADDR_W: write word address.
- `load_data` input INSTR_W: write data.
- `load_ready` output 1: loader request accepted this cycle.
- `mem_addr` output ADDR_W: IRAM address, registered.
- `mem_rnw` output 1: IRAM `read_not_write`, registered.
- `mem_wdata` output INSTR_W: write data toward the IRAM bus, registered.
- `mem_wdata_oe` output 1: tristate enable for `mem_wdata`; the top level builds the inout bus.
- `mem_rdata` input INSTR_W: IRAM data bus as read back.

## Operation
- A request transfers when `*_req && *_ready` at a rising edge.
- At most one of `fetch_ready`/`load_ready` is high in a cycle. Both are low outside IDLE.
- State machine:
  - IDLE, no request → IDLE.
  - IDLE, winning load → WR.
  - IDLE, winning fetch → RD.
  - WR → IDLE.
  - RD → RD_CAP.
  - RD_CAP → IDLE.
- Ready signals are combinational from state and requests.
- Default priority: the loader wins whenever `load_req` is high.
- WR entry, registered: `mem_addr`←`load_addr`, `mem_rnw`←0, `mem_wdata`←`load_data`, `mem_wdata_oe`←1.
- WR exit: `mem_rnw`←1, `mem_wdata_oe`←0.
- RD entry: `mem_addr`←`fetch_addr`, `mem_rnw`←1. The IRAM samples at the next edge.
- RD_CAP exit: `fetch_rdata`←`mem_rdata`, `fetch_rvalid`←1 for exactly one cycle.
- `fetch_rdata` holds its value until the next capture.
- `mem_addr` holds its last value in IDLE. No address range check; the full `ADDR_W` is passed through.
- Only one read is outstanding at a time, so fetch data is never reordered.

## Timing
- Reset values:
  - `mem_addr`=0, `mem_rnw`=1, `mem_wdata`=0, `mem_wdata_oe`=0.
  - `fetch_rdata`=0, `fetch_rvalid`=0.
  - Both readies reflect IDLE, i.e. follow the requests.
  - State=IDLE, starvation counter=0.
- Read latency: accept at edge N → `fetch_rvalid` high after edge N+2, for one cycle.
- Fetch throughput: one accepted read per 3 cycles.
- Write: accept at edge N → IRAM writes at edge N+1. The next request can be accepted at edge N+2.
- Simultaneous `load_req` and `fetch_req` in IDLE: the arbitration rule decides. The loser's request must stay asserted.
- A request dropped before it is accepted is legal and has no effect.
- `rst_n` asserted mid-operation: all registers return to their reset values immediately.
  - A pending read is discarded and no `fetch_rvalid` is produced.
  - `mem_wdata_oe` drops asynchronously.

## Configuration
- `IRAM_ARB_FAIRNESS_EN` defined:
  - A counter increments on each loader grant while `fetch_req` is high.
  - When the count reaches `STARVE_LIMIT`, the next IDLE arbitration grants fetch even if `load_req` is high.
  - The counter clears on any fetch grant, and when `fetch_req` is low in IDLE.
- `IRAM_ARB_FAIRNESS_EN` undefined: strict loader priority, no counter is synthesized, and `STARVE_LIMIT` is ignored.

## Test plan
- Reset then idle: outputs at reset values, `mem_rnw`=1, `mem_wdata_oe`=0, no `fetch_rvalid`.
- Write then read back:
  - Load addr 0x05, data 0x0_1200_0020, then fetch 0x05.
  - IRAM holds the value one edge after the load accept.
  - `fetch_rvalid` pulses 2 cycles after the fetch accept, with `fetch_rdata`=0x0_1200_0020.
- Back-to-back fetches of addresses 0..3 from a preloaded IRAM: accepts exactly 3 cycles apart, data returned in order, one `fetch_rvalid` per read.
- Simultaneous request:
  - `load_req` and `fetch_req` both held.
  - Without the macro, 6 loads complete before the first fetch.
  - With the macro and `STARVE_LIMIT`=4, the fetch is granted after 4 loads.
- Reset mid-read: assert `rst_n`=0 in RD_CAP → no `fetch_rvalid`, outputs at reset values; the next fetch after release completes normally.
